// File: rtl/alu_rr_scheduler_if.sv
// Request-side bus between requesting datapath blocks and the ALU scheduler.
// Per-requester fields are packed side by side, requester i at [i*W +: W].
interface alu_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*OP_W-1:0]   req_op;

  modport master (output req_valid, req_a, req_b, req_op, input req_ready);
  modport slave  (input req_valid, req_a, req_b, req_op, output req_ready);
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin sharing of one fixed-latency ALU between NUM_REQ requesters;
// an ID tag rides a latency-matched pipe so each result returns to its owner.
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int ALU_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_rr_scheduler_if.slave   req_bus,
  input  logic                hold,
  output logic                alu_en,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  input  logic [DATA_W-1:0]   alu_result,
  output logic [NUM_REQ-1:0]  resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic                idle,
  output logic [CNT_W-1:0]    ops_done
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_id_p0;
  logic [ID_W-1:0]    w_win;
  logic               w_found;
  logic               w_hs;
  logic               w_inflight;
  logic [ALU_LAT-1:0] r_tag_vld_p1;
  logic [ID_W-1:0]    r_tag_id_p1 [ALU_LAT];
  logic               w_tag_last_vld;
  logic [ID_W-1:0]    w_tag_last_id;
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Arbitration: first valid requester at or after rr_ptr+1, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_bus.req_valid[ID_W'(idx)]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  assign w_hs              = w_found & ~hold;
  assign req_bus.req_ready = w_hs ? (NUM_REQ'(1) << w_win) : '0;

  // Issue stage (p0): registered operands to the ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_en   <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      r_id_p0  <= '0;
      r_rr_ptr <= ID_W'(NUM_REQ - 1);
    end else begin
      alu_en <= w_hs;
      if (w_hs) begin
        alu_a    <= req_bus.req_a[w_win*DATA_W +: DATA_W];
        alu_b    <= req_bus.req_b[w_win*DATA_W +: DATA_W];
        alu_op   <= req_bus.req_op[w_win*OP_W +: OP_W];
        r_id_p0  <= w_win;
        r_rr_ptr <= w_win;
      end
    end
  end

  // Tag pipe (p1): tracks which requester owns each op inside the ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld_p1 <= '0;
      for (int i = 0; i < ALU_LAT; i++) r_tag_id_p1[i] <= '0;
    end else begin
      r_tag_vld_p1[0] <= alu_en;
      r_tag_id_p1[0]  <= r_id_p0;
      for (int i = 1; i < ALU_LAT; i++) begin
        r_tag_vld_p1[i] <= r_tag_vld_p1[i-1];
        r_tag_id_p1[i]  <= r_tag_id_p1[i-1];
      end
    end
  end

  assign w_tag_last_vld = r_tag_vld_p1[ALU_LAT-1];
  assign w_tag_last_id  = r_tag_id_p1[ALU_LAT-1];

  // Response stage (p2): ops_done moves in the same cycle as resp_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= '0;
      resp_data  <= '0;
      ops_done   <= '0;
    end else begin
      resp_valid <= w_tag_last_vld ? (NUM_REQ'(1) << w_tag_last_id) : '0;
      if (w_tag_last_vld) begin
        resp_data <= alu_result;
        ops_done  <= sat_inc(ops_done);
      end
    end
  end

  assign w_inflight = alu_en | (|r_tag_vld_p1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_hs) w_state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (hold && w_inflight)      w_state_nxt = S_DRAIN;
        else if (!w_inflight && !w_hs) w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (!w_inflight) w_state_nxt = S_IDLE;
        else if (!hold)  w_state_nxt = S_ACTIVE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign idle = (r_state == S_IDLE) & ~w_inflight;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: a driver queues expected responses,
// a monitor pops them as resp_valid strobes. A CNT_W=2 twin checks saturation.
module tb_alu_rr_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int OW = 4;

  logic clk;
  logic rst;
  logic hold;
  logic [DW-1:0] alu_result;

  logic          alu_en, alu_en2;
  logic [DW-1:0] alu_a, alu_b, alu_a2, alu_b2;
  logic [OW-1:0] alu_op, alu_op2;
  logic [NR-1:0] resp_valid, resp_valid2;
  logic [DW-1:0] resp_data, resp_data2;
  logic          idle, idle2;
  logic [15:0]   ops_done;
  logic [1:0]    ops_done2;

  alu_rr_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW)) u_if ();
  alu_rr_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW)) u_if2 ();

  assign u_if2.req_valid = u_if.req_valid;
  assign u_if2.req_a     = u_if.req_a;
  assign u_if2.req_b     = u_if.req_b;
  assign u_if2.req_op    = u_if.req_op;

  alu_rr_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW), .ALU_LAT(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_bus(u_if), .hold(hold),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .resp_valid(resp_valid), .resp_data(resp_data),
    .idle(idle), .ops_done(ops_done)
  );

  alu_rr_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW), .ALU_LAT(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_bus(u_if2), .hold(hold),
    .alu_en(alu_en2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2),
    .alu_result(alu_result), .resp_valid(resp_valid2), .resp_data(resp_data2),
    .idle(idle2), .ops_done(ops_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage ALU: 0 ADD, 1 SUB, 2 AND, 3 XOR
  logic [DW-1:0] alu_p1;
  always @(posedge clk) begin
    case (alu_op)
      4'd0:    alu_p1 <= alu_a + alu_b;
      4'd1:    alu_p1 <= alu_a - alu_b;
      4'd2:    alu_p1 <= alu_a & alu_b;
      4'd3:    alu_p1 <= alu_a ^ alu_b;
      default: alu_p1 <= '0;
    endcase
    alu_result <= alu_p1;
  end

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] exp_res [NR];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            resp_cnt = 0;
  bit            seen_drain = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OW-1:0] op, input logic [DW-1:0] e);
    u_if.req_a[i*DW +: DW] = a;
    u_if.req_b[i*DW +: DW] = b;
    u_if.req_op[i*OW +: OW] = op;
    exp_res[i] = e;
  endtask

  task automatic issue_cycle(input logic [NR-1:0] v, input logic h,
                             input logic [NR-1:0] exp_rdy, input bit push);
    @(negedge clk);
    u_if.req_valid = v;
    hold = h;
    #1;
    chk("req_ready", {28'd0, u_if.req_ready}, {28'd0, exp_rdy});
    if (push) begin
      for (int i = 0; i < NR; i++)
        if (exp_rdy[i]) q.push_back('{id: i, data: exp_res[i], due: cyc + 4});
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        resp_cnt = 0;
      end else begin
        if (dut.r_state == 2'd2) seen_drain = 1;
        if (resp_valid != '0) begin
          if (q.size() == 0) begin
            chk("unexpected_resp", {28'd0, resp_valid}, 0);
          end else begin
            e = q.pop_front();
            resp_cnt++;
            chk("resp_valid", {28'd0, resp_valid}, 32'd1 << e.id);
            chk("resp_data", {24'd0, resp_data}, {24'd0, e.data});
            chk("resp_latency", cyc, e.due);
            chk("ops_done", {16'd0, ops_done}, resp_cnt);
            chk("ops_done_sat", {30'd0, ops_done2}, (resp_cnt > 3) ? 3 : resp_cnt);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : driver
    rst = 1'b1;
    hold = 1'b0;
    u_if.req_valid = '0;
    u_if.req_a = '0;
    u_if.req_b = '0;
    u_if.req_op = '0;
    set_ops(0, 8'hFF, 8'h02, 4'd0, 8'h01);
    set_ops(1, 8'h50, 8'h20, 4'd1, 8'h30);
    set_ops(2, 8'h05, 8'h03, 4'd0, 8'h08);
    set_ops(3, 8'hAA, 8'hFF, 4'd3, 8'h55);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_alu_en", alu_en, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_idle", idle, 1);
    rst = 1'b0;

    // Single op from requester 2
    issue_cycle(4'b0100, 1'b0, 4'b0100, 1);
    issue_cycle(4'b0000, 1'b0, 4'b0000, 1);
    chk("issue_alu_en", alu_en, 1);
    chk("issue_alu_a", alu_a, 8'h05);
    chk("issue_alu_b", alu_b, 8'h03);
    chk("issue_alu_op", alu_op, 4'd0);
    chk("busy_idle", idle, 0);
    wait_drain();
    @(negedge clk);
    #1;
    chk("single_idle", idle, 1);
    chk("single_ops_done", ops_done, 1);

    // All four requesters continuously valid
    set_ops(2, 8'hF0, 8'h3C, 4'd2, 8'h30);
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      issue_cycle(4'b1111, 1'b0, 4'b0001, 1);
      issue_cycle(4'b1111, 1'b0, 4'b0010, 1);
      issue_cycle(4'b1111, 1'b0, 4'b0100, 1);
      issue_cycle(4'b1111, 1'b0, 4'b1000, 1);
    end
    issue_cycle(4'b0000, 1'b0, 4'b0000, 1);
    wait_drain();

    // Requesters 1 and 3 contend after a grant to 1
    issue_cycle(4'b0010, 1'b0, 4'b0010, 1);
    for (int r = 0; r < 3; r++) begin
      issue_cycle(4'b1010, 1'b0, 4'b1000, 1);
      issue_cycle(4'b1010, 1'b0, 4'b0010, 1);
    end
    issue_cycle(4'b0000, 1'b0, 4'b0000, 1);
    wait_drain();

    // Three ops, then hold while requests stay up
    issue_cycle(4'b0111, 1'b0, 4'b0100, 1);
    issue_cycle(4'b0111, 1'b0, 4'b0001, 1);
    issue_cycle(4'b0111, 1'b0, 4'b0010, 1);
    seen_drain = 0;
    repeat (4) issue_cycle(4'b0111, 1'b1, 4'b0000, 1);
    wait_drain();
    @(negedge clk);
    #1;
    chk("hold_idle", idle, 1);
    chk("hold_seen_drain", seen_drain, 1);
    issue_cycle(4'b0111, 1'b0, 4'b0100, 1);
    issue_cycle(4'b0000, 1'b0, 4'b0000, 1);
    wait_drain();

    // Asynchronous reset with an op in the issue stage
    pulse_reset();
    issue_cycle(4'b0001, 1'b0, 4'b0001, 0);
    @(posedge clk);
    #1;
    u_if.req_valid = '0;
    chk("pre_rst_alu_en", alu_en, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_alu_en", alu_en, 0);
    chk("async_rst_idle", idle, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("discard_ops_done", ops_done, 0);
    chk("discard_ops_done_sat", ops_done2, 0);

    // Five back-to-back ops from requester 0 for counter saturation
    repeat (5) issue_cycle(4'b0001, 1'b0, 4'b0001, 1);
    issue_cycle(4'b0000, 1'b0, 4'b0000, 1);
    wait_drain();
    @(negedge clk);
    #1;
    chk("final_ops_done", ops_done, 5);
    chk("final_ops_done_sat", ops_done2, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one fixed-latency ALU between NUM_REQ requesters.
- Each requester has a valid/ready request port.
- Grants are issued round-robin, one op per cycle, into a registered issue stage.
- Each op carries an ID tag through a latency-matched pipeline, so the registered result returns to the originating requester.
- Sits between the requesting datapath blocks and the ALU. A hold input lets software quiesce the ALU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand/result width.
- OP_W, 4, opcode width (passed through unmodified).
- ALU_LAT, 2, cycles from alu_en high to alu_result valid (>=1).
- CNT_W, 16, width of completed-op counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, combinational.
- req_a  in  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  operand B, same packing.
- req_op  in  NUM_REQ*OP_W  opcode, same packing.
- hold  in  1  stop accepting new requests, drain in-flight ops.
- alu_en  out  1  issue strobe to ALU, registered.
- alu_a  out  DATA_W  registered operand A.
- alu_b  out  DATA_W  registered operand B.
- alu_op  out  OP_W  registered opcode.
- alu_result  in  DATA_W  ALU result, valid ALU_LAT cycles after alu_en.
- resp_valid  out  NUM_REQ  one-hot response strobe, registered.
- resp_data  out  DATA_W  registered result.
- idle  out  1  high when no op is in issue stage or ALU pipe, and state is IDLE.
- ops_done  out  CNT_W  saturating count of responses delivered.

Behaviour:
Reset (rst=1, asynchronous):
- Outputs: alu_en=0, alu_a/b/op=0, resp_valid=0, resp_data=0, ops_done=0, idle=1.
- Internal: rr pointer=NUM_REQ-1 (so requester 0 has first priority), tag pipe cleared, state=IDLE.
- Reset mid-operation discards all in-flight ops; no response is ever produced for them.

Arbitration:
- Search starts at rr_ptr+1 mod NUM_REQ. The first asserted req_valid wins.
- req_ready is one-hot on the winner, all zero if hold=1 or no valid.
- Handshake is req_valid[i] & req_ready[i]. On handshake, rr_ptr <= i. rr_ptr is unchanged otherwise.
- A requester must hold valid and operands stable until ready. Dropping valid early is legal but simply loses the slot.
- Max one accept per cycle. Back-to-back accepts every cycle allowed (full throughput).

Issue and tag pipeline:
- Handshake in cycle t: alu_en=1 with that requester's operands in cycle t+1.
- No handshake: alu_en=0 and alu_a/b/op hold their previous values.
- Tag shift register, depth ALU_LAT, entry {vld, id[clog2(NUM_REQ)]}. It is loaded from the issue stage each cycle alu_en is sampled.
- alu_result is sampled when the tag at depth ALU_LAT is valid, in cycle t+1+ALU_LAT.
- resp_valid[id]=1 for exactly one cycle, with resp_data=alu_result, in cycle t+2+ALU_LAT. Total latency from handshake = ALU_LAT+2.
- resp has no backpressure; requesters must always accept.
- A new accept and a response in the same cycle are independent and both occur.

ops_done:
- +1 per resp_valid cycle.
- Saturates at all-ones (no wrap).

State machine (drives idle):
- inflight = issue stage valid OR any tag vld.
- IDLE -> ACTIVE on handshake.
- ACTIVE -> DRAIN when hold=1 and inflight.
- ACTIVE -> IDLE when !inflight and no handshake.
- DRAIN -> IDLE when !inflight.
- DRAIN -> ACTIVE if hold drops while inflight.
- IDLE with hold=1 stays IDLE.
- idle = (state==IDLE) & !inflight.
- hold asserted in the same cycle as req_valid blocks that request: ready=0.

Test Plan:
- Reset, then requester 2 sends a=8'h05, b=8'h03, op ADD (ALU_LAT=2): req_ready[2] same cycle; alu_en 1 cycle later with a=5, b=3; resp_valid=4'b0100, resp_data=8'h08 four cycles after handshake; ops_done=1; idle returns to 1.
- All four req_valid held high for 8 cycles: grants in order 0,1,2,3,0,1,2,3, one per cycle; responses return in the same order, each 4 cycles after its grant.
- Requesters 1 and 3 always valid, last grant was 1: next grant 3, then 1, alternating strictly; no starvation.
- Three ops issued, then hold=1 the next cycle: req_ready stays 0; the three responses still arrive; state passes through DRAIN; idle=1 after the last resp; hold=0 resumes grants.
- rst pulsed asynchronously 1 cycle after an issue: alu_en and resp_valid go 0 immediately; no response ever appears for that op; ops_done=0.
- CNT_W=2, 5 ops: ops_done reads 1,2,3,3,3 (saturates).
